// File: rtl/booth_r4_mul_if.sv
// Request/result bundle for the radix-4 Booth multiplier.
//   start, signed_mode, x, y : request side, driven by the client (master)
//   busy, done, z            : status/result side, driven by the multiplier (slave)
interface booth_r4_mul_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   z;

  modport master (
    output start, signed_mode, x, y,
    input  busy, done, z
  );

  modport slave (
    input  start, signed_mode, x, y,
    output busy, done, z
  );
endinterface

// File: rtl/booth_r4_mul.sv
// Sequential radix-4 (modified) Booth multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Retires two multiplier bits per cycle; WIDTH/2+1 iterations per product in either mode.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; aborts any multiplication in flight
//   bus    slave side of booth_r4_mul_if:
//            start/signed_mode/x/y sampled only while idle
//            busy high during iterations, done one-cycle pulse with z updated,
//            z holds the last product until the next completion
module booth_r4_mul #(
  parameter int unsigned WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  booth_r4_mul_if.slave  bus
);

  localparam int unsigned N  = WIDTH / 2 + 1;   // iterations
  localparam int unsigned EW = WIDTH + 2;       // extended operand width
  localparam int unsigned AW = WIDTH + 3;       // accumulator width, room for +/-2M
  localparam int unsigned CW = $clog2(N) + 1;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_r4_mul: WIDTH must be even and >= 4");
  end

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e               state_q, state_d;
  logic [EW-1:0]        m_q, m_d;
  logic [EW-1:0]        q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   z_q, z_d;

  logic [EW-1:0]        x_ext, y_ext;
  logic [AW-1:0]        m_ext, pp, sum;

  // Two extra bits: sign copies in signed mode, zeros in unsigned mode, so the
  // unsigned operand is always a non-negative two's complement value.
  assign x_ext = {{2{bus.signed_mode & bus.x[WIDTH-1]}}, bus.x};
  assign y_ext = {{2{bus.signed_mode & bus.y[WIDTH-1]}}, bus.y};
  assign m_ext = {m_q[EW-1], m_q};

  // Booth recoding of {q1, q0, q-1}
  always_comb begin
    pp = '0;
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext << 1;
      3'b100:         pp = -(m_ext << 1);
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = '0;
    endcase
  end

  assign sum = acc_q + pp;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    z_d     = z_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          m_d     = x_ext;
          q_d     = y_ext;
          qm1_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        // Arithmetic shift of {sum, Q, q-1} right by two
        acc_d = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_d   = {sum[1:0], q_q[EW-1:2]};
        qm1_d = q_q[1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          z_d     = {acc_d[WIDTH-3:0], q_d};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      z_q     <= z_d;
    end
  end

  assign bus.busy = (state_q == StCalc);
  assign bus.done = done_q;
  assign bus.z    = z_q;

endmodule

// File: tb/tb_booth_r4_mul.sv
// Self-checking bench for booth_r4_mul at WIDTH = 4, 8 and 16.
module tb_booth_r4_mul;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_r4_mul_if #(.WIDTH(4))  if4 ();
  booth_r4_mul_if #(.WIDTH(8))  if8 ();
  booth_r4_mul_if #(.WIDTH(16)) if16 ();

  booth_r4_mul #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  booth_r4_mul #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  booth_r4_mul #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_in(input int w, input logic st, input logic sm,
                        input logic [15:0] a, input logic [15:0] b);
    case (w)
      4: begin
        if4.start = st; if4.signed_mode = sm; if4.x = a[3:0]; if4.y = b[3:0];
      end
      8: begin
        if8.start = st; if8.signed_mode = sm; if8.x = a[7:0]; if8.y = b[7:0];
      end
      default: begin
        if16.start = st; if16.signed_mode = sm; if16.x = a; if16.y = b;
      end
    endcase
  endtask

  function automatic logic get_busy(input int w);
    case (w)
      4:       return if4.busy;
      8:       return if8.busy;
      default: return if16.busy;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      4:       return if4.done;
      8:       return if8.done;
      default: return if16.done;
    endcase
  endfunction

  function automatic logic [31:0] get_z(input int w);
    case (w)
      4:       return {24'b0, if4.z};
      8:       return {16'b0, if8.z};
      default: return if16.z;
    endcase
  endfunction

  // Reference: interpret operands as integers, multiply, keep 2*w bits
  function automatic logic [31:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic sm);
    longint av, bv, p;
    logic [63:0] pm;
    av = longint'(a) & ((longint'(1) << w) - 1);
    bv = longint'(b) & ((longint'(1) << w) - 1);
    if (sm && a[w-1]) av = av - (longint'(1) << w);
    if (sm && b[w-1]) bv = bv - (longint'(1) << w);
    p  = av * bv;
    pm = p & ((longint'(1) << (2 * w)) - 1);
    return pm[31:0];
  endfunction

  // Issues one request and waits for done. Returns the product, the number of
  // edges from the start edge to the done edge (-1 on timeout) and a count of
  // busy/done/z protocol violations seen on the way.
  task automatic run(input int w, input logic sm, input logic [15:0] a, input logic [15:0] b,
                     output logic [31:0] res, output int lat, output int inv);
    logic [31:0] zprev;
    set_in(w, 1'b1, sm, a, b);
    @(posedge clk); #1;
    set_in(w, 1'b0, sm, a, b);
    zprev = get_z(w);
    lat = 0;
    inv = 0;
    if (!get_busy(w) || get_done(w)) inv++;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      lat++;
      if (get_done(w)) break;
      if (!get_busy(w) || get_z(w) !== zprev) inv++;
    end
    if (!get_done(w)) lat = -1;
    else if (get_busy(w)) inv++;
    res = get_z(w);
  endtask

  task automatic run_check(input string tag, input int w, input logic sm,
                           input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    logic [31:0] res;
    int lat, inv;
    run(w, sm, a, b, res, lat, inv);
    if (res !== exp || lat != w / 2 + 1 || inv != 0)
      $display("FAIL %s w=%0d sm=%0d x=%h y=%h: z=%h lat=%0d viol=%0d, required z=%h lat=%0d viol=0",
               tag, w, sm, a, b, res, lat, inv, exp, w / 2 + 1);
    n_total++;
    if (res === exp && lat == w / 2 + 1 && inv == 0) n_pass++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    int lat, inv, done_seen;

    tbl[0] = '{a: 16'hFFFD, b: 16'h0007, sm: 1'b1, exp: 32'hFFFF_FFEB};
    tbl[1] = '{a: 16'h8000, b: 16'h8000, sm: 1'b1, exp: 32'h4000_0000};
    tbl[2] = '{a: 16'h7FFF, b: 16'h8000, sm: 1'b1, exp: 32'hC000_8000};
    tbl[3] = '{a: 16'hFFFF, b: 16'hFFFF, sm: 1'b0, exp: 32'hFFFE_0001};
    tbl[4] = '{a: 16'hFFFF, b: 16'hFFFF, sm: 1'b1, exp: 32'h0000_0001};
    tbl[5] = '{a: 16'h8000, b: 16'h8000, sm: 1'b0, exp: 32'h4000_0000};
    tbl[6] = '{a: 16'h1234, b: 16'h0000, sm: 1'b1, exp: 32'h0000_0000};

    set_in(4, 1'b0, 1'b0, 16'h0, 16'h0);
    set_in(8, 1'b0, 1'b0, 16'h0, 16'h0);
    set_in(16, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset state
    #12;
    check("reset.busy", {31'b0, if16.busy}, 32'd0);
    check("reset.done", {31'b0, if16.done}, 32'd0);
    check("reset.z", if16.z, 32'd0);
    check("reset.z4", get_z(4), 32'd0);

    // Reset mid-operation aborts without done
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    set_in(16, 1'b1, 1'b1, 16'hFFFD, 16'h0007);
    @(posedge clk); #1;
    set_in(16, 1'b0, 1'b1, 16'hFFFD, 16'h0007);
    repeat (3) @(posedge clk);
    #1;
    check("abort.busy_before", {31'b0, if16.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.busy_in_reset", {31'b0, if16.busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (if16.done || if16.busy) done_seen++;
    end
    check("abort.no_done", 32'(done_seen), 32'd0);
    check("abort.z", if16.z, 32'd0);

    // Directed vectors at WIDTH=16, issued back-to-back in the done cycle
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) run_check($sformatf("tbl[%0d]", i), 16, tbl[i].sm,
                                          tbl[i].a, tbl[i].b, tbl[i].exp);

    // start held through CALC with new operands, then still high in the done cycle
    repeat (2) @(posedge clk);
    #1;
    set_in(16, 1'b1, 1'b0, 16'd3, 16'd5);
    @(posedge clk); #1;
    set_in(16, 1'b1, 1'b0, 16'd7, 16'd9);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (if16.done) begin lat = k; break; end
    end
    check("hold.lat", 32'(lat), 32'd9);
    check("hold.z", if16.z, 32'd15);
    check("hold.busy_in_done", {31'b0, if16.busy}, 32'd0);
    @(posedge clk); #1;
    check("hold.restart_busy", {31'b0, if16.busy}, 32'd1);
    set_in(16, 1'b0, 1'b0, 16'd7, 16'd9);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (if16.done) begin lat = k; break; end
    end
    check("b2b.lat", 32'(lat), 32'd9);
    check("b2b.z", if16.z, 32'd63);
    @(posedge clk); #1;
    check("b2b.done_pulse", {31'b0, if16.done}, 32'd0);

    // Exhaustive at WIDTH=4
    for (int sm = 0; sm < 2; sm++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run_check("ex4", 4, sm[0], 16'(a), 16'(b), model(4, 16'(a), 16'(b), sm[0]));

    // Random at WIDTH=8 and 16
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a, b;
      logic sm;
      a  = 16'($urandom);
      b  = 16'($urandom);
      sm = 1'($urandom);
      run_check("rnd8", 8, sm, a, b, model(8, a, b, sm));
    end
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a, b;
      logic sm;
      a  = 16'($urandom);
      b  = 16'($urandom);
      sm = 1'($urandom);
      run_check("rnd16", 16, sm, a, b, model(16, a, b, sm));
    end

    // Unused handle to keep the result locals meaningful for a manual spot check
    run(8, 1'b1, 16'h0080, 16'h007F, res, lat, inv);
    check("spot8.z", res, 32'h0000_C080);
    check("spot8.lat", 32'(lat), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
